fft_addr_sequencer: RTL and testbench
=====================================

FFT_ADDR_SEQUENCER -- requirements
Module: fft_addr_sequencer

Interface
REQ-001 Parameter N, default 8, SHALL set FFT length; power of two, 4..1024.
REQ-002 Parameter LOG2N, default clog2(N), SHALL set address width and stage count.
REQ-003 Parameter STAGE_GAP, default 2, SHALL set idle cycles between stages (range 0..15).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to begin one transform; sampled only in IDLE.
REQ-007 stall  in  1  downstream hold; freezes butterfly advance.
REQ-008 bf_valid  out  1  butterfly address tuple is valid.
REQ-009 addr_a  out  LOG2N  upper butterfly operand address.
REQ-010 addr_b  out  LOG2N  lower butterfly operand address.
REQ-011 tw_idx  out  LOG2N-1  twiddle ROM index.
REQ-012 stage  out  clog2(LOG2N)+1  current stage number.
REQ-013 busy_set  out  1  one-cycle pulse; drives S of downstream busy SR flag.
REQ-014 busy_clr  out  1  one-cycle pulse; drives R of downstream busy SR flag.
REQ-015 done  out  1  one-cycle end-of-transform pulse.

Function
REQ-016 FSM states: IDLE, RUN, GAP, DONE; all outputs decoded from registered state/counters only, with no combinational input-to-output path.
REQ-017 IDLE: start=1 -> RUN next cycle with s=0, k=0; start=0 -> stay.
REQ-018 busy_set SHALL be high exactly the first cycle of RUN following IDLE.
REQ-019 RUN: bf_valid=1; a tuple transfers in any cycle with bf_valid=1 and stall=0.
REQ-020 RUN with stall=1: k, s, state and all outputs SHALL hold unchanged.
REQ-021 RUN, transfer, k<N/2-1: k <= k+1.
REQ-022 RUN, transfer, k=N/2-1, s<LOG2N-1: s <= s+1, k <= 0, -> GAP (or directly RUN if STAGE_GAP=0).
REQ-023 RUN, transfer, k=N/2-1, s=LOG2N-1: -> DONE.
REQ-024 GAP: bf_valid=0; count STAGE_GAP cycles, then -> RUN; stall ignored in GAP.
REQ-025 DONE: done=1 and busy_clr=1 for exactly one cycle, then -> IDLE.
REQ-026 start outside IDLE SHALL be ignored (no queueing); start in DONE cycle ignored.
REQ-027 Address math, span=2^s: group=k>>s; pos=k&(span-1); addr_a=group*2*span+pos; addr_b=addr_a+span; tw_idx=pos<<(LOG2N-1-s); all unsigned, no overflow by construction.
REQ-028 When bf_valid=0, addr_a/addr_b/tw_idx SHALL read 0; stage reads current s (0 in IDLE).
REQ-029 Unstalled transform SHALL occupy LOG2N*N/2 + (LOG2N-1)*STAGE_GAP cycles in RUN/GAP, plus one DONE cycle.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, s=0, k=0, gap count=0, all outputs 0, from any state including mid-RUN.
REQ-031 Reset SHALL NOT emit busy_clr; the downstream SR flag is cleared by its own reset.
REQ-032 reset SHALL dominate start and stall in the same cycle.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding constants and the LOG2N/counter width helper function.
REQ-034 Address/twiddle computation SHALL be one combinational sub-module, fft_bf_addr_gen (inputs s, k; outputs addr_a, addr_b, tw_idx).
REQ-035 Target size 120-400 lines of RTL total.

Verification
REQ-036 N=8, STAGE_GAP=2, start pulse, stall=0 -> busy_set cycle 1; stage0 (a,b)=(0,1),(2,3),(4,5),(6,7), tw=0; 2 gap cycles; stage1 (0,2),(1,3),(4,6),(5,7), tw=0,2,0,2; 2 gap cycles; stage2 (0,4),(1,5),(2,6),(3,7), tw=0,1,2,3; done+busy_clr at cycle 17.
REQ-037 N=8, stall=1 for 3 cycles at stage1 k=2 -> tuple (4,6,tw=0) held for 4 cycles, done delayed exactly 3 cycles to cycle 20.
REQ-038 start re-asserted during RUN and during DONE -> ignored; exactly one done pulse; new start in IDLE afterwards begins a fresh transform.
REQ-039 reset asserted at stage2 k=1 -> next cycle all outputs 0, state IDLE, no busy_clr; subsequent start yields complete 12-butterfly sequence.
REQ-040 N=16, STAGE_GAP=0 -> 32 consecutive bf_valid cycles, stage3 tuples (k, k+8, tw=k), done at cycle 33.
REQ-041 Scoreboard SHALL check every transferred tuple against REQ-027 and that each operand address appears exactly once per stage.

Source files
------------

// File: rtl/fft_addr_sequencer_pkg.sv
// Shared definitions for the FFT address sequencer: FSM state encoding,
// gap counter width and the width helpers used to size stage/counter fields.
package fft_addr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Inter-stage gap counter; STAGE_GAP is limited to 0..15.
    localparam int GAP_CNT_W = 4;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2_int(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Width of the stage number field for a transform with log2n stages.
    function automatic int stage_w(input int log2n);
        return clog2_int(log2n) + 1;
    endfunction

endpackage

// File: rtl/fft_addr_sequencer_if.sv
// Butterfly address bus between the sequencer and the butterfly datapath.
// Handshake: a tuple (addr_a, addr_b, tw_idx, stage) transfers on every rising
// clk edge where bf_valid=1 and stall=0; while stall=1 the master holds the
// tuple unchanged. stall is ignored whenever bf_valid=0.
interface fft_addr_sequencer_if
    import fft_addr_sequencer_pkg::*;
#(
    parameter int LOG2N = 3
) ();

    localparam int SW = stage_w(LOG2N);

    logic             bf_valid;
    logic             stall;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic [SW-1:0]    stage;

    modport master (
        output bf_valid,
        output addr_a,
        output addr_b,
        output tw_idx,
        output stage,
        input  stall
    );

    modport slave (
        input  bf_valid,
        input  addr_a,
        input  addr_b,
        input  tw_idx,
        input  stage,
        output stall
    );

endinterface

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 butterfly address generator. For stage s and butterfly k:
// span = 2^s, pos = k mod span, addr_a = (k - pos)*2 + pos, addr_b = addr_a + span,
// tw_idx = pos << (LOG2N-1-s). Purely combinational.
module fft_bf_addr_gen
    import fft_addr_sequencer_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [stage_w(LOG2N)-1:0] s,
    input  logic [LOG2N-2:0]          k,
    output logic [LOG2N-1:0]          addr_a,
    output logic [LOG2N-1:0]          addr_b,
    output logic [LOG2N-2:0]          tw_idx
);

    localparam int SW = stage_w(LOG2N);
    localparam int KW = LOG2N - 1;

    logic [KW-1:0]    mask;
    logic [KW-1:0]    pos;
    logic [KW-1:0]    hi;
    logic [SW-1:0]    tw_shift;

    // Split k into group part (hi) and position part (pos), then interleave a zero bit at s.
    // In the last stage the KW-bit shift overflows to 0, so mask becomes all ones as required.
    always_comb begin
        mask     = (KW'(1) << s) - KW'(1);
        pos      = k & mask;
        hi       = k & ~mask;
        addr_a   = {hi, 1'b0} | {1'b0, pos};
        addr_b   = addr_a | (LOG2N'(1) << s);
        tw_shift = SW'(KW) - s;
        tw_idx   = pos << tw_shift;
    end

endmodule

// File: rtl/fft_addr_sequencer.sv
// In-place radix-2 FFT address sequencer: walks LOG2N stages of N/2 butterflies,
// inserting STAGE_GAP idle cycles between stages, with downstream stall support
// and busy_set/busy_clr pulses for an external busy SR flag.
module fft_addr_sequencer
    import fft_addr_sequencer_pkg::*;
#(
    parameter int N         = 8,
    parameter int LOG2N     = $clog2(N),
    parameter int STAGE_GAP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    fft_addr_sequencer_if.master bus,
    output logic                 busy_set,
    output logic                 busy_clr,
    output logic                 done,
    output state_t               fsm_state
);

    localparam int SW = stage_w(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (STAGE_GAP == 0) ? '0 : GAP_CNT_W'(STAGE_GAP - 1);

    state_t               state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [KW-1:0]        k_q, k_d;
    logic [GAP_CNT_W-1:0] gcnt_q, gcnt_d;
    logic                 first_q, first_d;

    logic                 xfer;
    logic                 last_k;
    logic                 last_s;
    logic [LOG2N-1:0]     gen_a;
    logic [LOG2N-1:0]     gen_b;
    logic [LOG2N-2:0]     gen_tw;

    fft_bf_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .s      (s_q),
        .k      (k_q),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    assign xfer   = (state_q == ST_RUN) && !bus.stall;
    assign last_k = (k_q == K_LAST);
    assign last_s = (s_q == S_LAST);

    // State and counter registers; reset returns to IDLE silently (no busy_clr).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            gcnt_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            gcnt_q  <= gcnt_d;
            first_q <= first_d;
        end
    end

    // Next-state logic: butterfly walk, inter-stage gap and end-of-transform.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        gcnt_d  = gcnt_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                    first_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (!last_k) begin
                        k_d = k_q + KW'(1);
                    end else if (!last_s) begin
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                        gcnt_d  = '0;
                        state_d = (STAGE_GAP == 0) ? ST_RUN : ST_GAP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GAP_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = '0;
                k_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only. busy_set is a true one-cycle
    // pulse even if the first RUN cycle is stalled; re-setting an SR flag is harmless.
    always_comb begin
        bus.bf_valid = (state_q == ST_RUN);
        bus.addr_a   = (state_q == ST_RUN) ? gen_a  : '0;
        bus.addr_b   = (state_q == ST_RUN) ? gen_b  : '0;
        bus.tw_idx   = (state_q == ST_RUN) ? gen_tw : '0;
        bus.stage    = s_q;
        busy_set     = first_q;
        busy_clr     = (state_q == ST_DONE);
        done         = (state_q == ST_DONE);
        fsm_state    = state_q;
    end

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Scoreboard bench for fft_addr_sequencer: N=8/STAGE_GAP=2 and N=16/STAGE_GAP=0 instances.
module tb_fft_addr_sequencer;
    import fft_addr_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start8;
    logic start16;
    logic busy_set8, busy_clr8, done8;
    logic busy_set16, busy_clr16, done16;
    state_t fsm8, fsm16;

    fft_addr_sequencer_if #(.LOG2N(3)) bus8 ();
    fft_addr_sequencer_if #(.LOG2N(4)) bus16 ();

    fft_addr_sequencer #(.N(8), .STAGE_GAP(2)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start8),
        .bus       (bus8),
        .busy_set  (busy_set8),
        .busy_clr  (busy_clr8),
        .done      (done8),
        .fsm_state (fsm8)
    );

    fft_addr_sequencer #(.N(16), .STAGE_GAP(0)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .start     (start16),
        .bus       (bus16),
        .busy_set  (busy_set16),
        .busy_clr  (busy_clr16),
        .done      (done16),
        .fsm_state (fsm16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int done_cnt = 0;
    int hold_cnt = 0;

    logic [31:0] exp8_q[$];
    logic [31:0] exp16_q[$];
    int          exp_done_q[$];
    int          exp_bs_q[$];

    logic [15:0] seen_m[2];
    int          seen_n[2];

    // N=8 tuples, hand-computed: stage0, stage1, stage2
    int tab_a [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_b [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_tw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tup(input int st, input int a, input int b, input int tw);
        return {8'(st), 8'(a), 8'(b), 8'(tw)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic mon(input int id, input logic v, input logic st, input int sg, input int a,
                       input int b, input int tw, input logic bs, input logic dn, input logic clr,
                       input state_t fs, input int nhalf);
        logic [31:0] act;
        logic [31:0] e;
        int have;
        act = tup(sg, a, b, tw);
        have = (id == 0) ? exp8_q.size() : exp16_q.size();
        if (v && !st) begin
            if (have == 0) begin
                check("unexpected_tuple", act, 32'hffff_ffff);
            end else begin
                e = (id == 0) ? exp8_q.pop_front() : exp16_q.pop_front();
                check(id == 0 ? "tuple8" : "tuple16", act, e);
            end
            check("operand_unique", {30'd0, seen_m[id][a], seen_m[id][b]}, 32'd0);
            seen_m[id][a] = 1'b1;
            seen_m[id][b] = 1'b1;
            seen_n[id]++;
            if (seen_n[id] == nhalf) begin
                check("operand_cover", {16'd0, seen_m[id]}, (32'd1 << (2 * nhalf)) - 32'd1);
                seen_m[id] = '0;
                seen_n[id] = 0;
            end
        end else if (v && st) begin
            hold_cnt++;
            if (have != 0) begin
                e = (id == 0) ? exp8_q[0] : exp16_q[0];
                check("stall_hold", act, e);
            end
        end else begin
            check("idle_addr_zero", {8'(a), 8'(b), 8'(tw)}, 32'd0);
        end
        if (fs == ST_IDLE) begin
            seen_m[id] = '0;
            seen_n[id] = 0;
        end
        if (bs) begin
            if (exp_bs_q.size() == 0) check("unexpected_busy_set", 32'(cyc - t0), 32'hffff_ffff);
            else check("busy_set_cycle", 32'(cyc - t0), 32'(exp_bs_q.pop_front()));
        end
        if (dn || clr) begin
            check("done_eq_busy_clr", {31'd0, clr}, {31'd0, dn});
        end
        if (dn) begin
            done_cnt++;
            if (exp_done_q.size() == 0) check("unexpected_done", 32'(cyc - t0), 32'hffff_ffff);
            else check("done_cycle", 32'(cyc - t0), 32'(exp_done_q.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus8.bf_valid, bus8.stall, int'(bus8.stage), int'(bus8.addr_a), int'(bus8.addr_b),
            int'(bus8.tw_idx), busy_set8, done8, busy_clr8, fsm8, 4);
        mon(1, bus16.bf_valid, bus16.stall, int'(bus16.stage), int'(bus16.addr_a),
            int'(bus16.addr_b), int'(bus16.tw_idx), busy_set16, done16, busy_clr16, fsm16, 8);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int count);
        for (int i = 0; i < count; i++) exp8_q.push_back(tup(i / 4, tab_a[i], tab_b[i], tab_tw[i]));
    endtask

    task automatic push16();
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 16; a++) begin
                if ((a & (1 << s)) == 0)
                    exp16_q.push_back(tup(s, a, a + (1 << s), (a % (1 << s)) * (8 >> s)));
            end
        end
    endtask

    task automatic drive_start(input int id);
        tick();
        if (id == 0) start8 = 1'b1; else start16 = 1'b1;
        t0 = cyc;
        exp_bs_q.push_back(1);
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        n_tests++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        reset = 1'b1;
        start8 = 1'b0;
        start16 = 1'b0;
        bus8.stall = 1'b0;
        bus16.stall = 1'b0;
        seen_m[0] = '0;
        seen_m[1] = '0;
        seen_n[0] = 0;
        seen_n[1] = 0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_state8", {fsm8, bus8.bf_valid, busy_set8, busy_clr8, done8, 3'(bus8.stage)}, 0);
        check("reset_state16", {fsm16, bus16.bf_valid, busy_set16, busy_clr16, done16, 3'(bus16.stage)}, 0);

        // Basic N=8 transform
        push8(12);
        exp_done_q.push_back(17);
        drive_start(0);
        wait_done(40);
        repeat (3) tick();

        // Stall for 3 cycles at stage1 k=2 (cycle 9)
        push8(12);
        exp_done_q.push_back(20);
        hold_cnt = 0;
        drive_start(0);
        repeat (8) tick();
        bus8.stall = 1'b1;
        repeat (3) tick();
        bus8.stall = 1'b0;
        wait_done(40);
        check("stall_hold_cycles", 32'(hold_cnt), 32'd3);
        repeat (3) tick();

        // start during RUN and during DONE is ignored
        push8(12);
        exp_done_q.push_back(17);
        d0 = done_cnt;
        drive_start(0);
        repeat (2) tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (13) tick();
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (20) tick();
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("ignored_start_idle", {30'd0, fsm8}, {30'd0, ST_IDLE});
        push8(12);
        exp_done_q.push_back(17);
        drive_start(0);
        wait_done(40);
        repeat (3) tick();

        // Reset at stage2 k=1 (cycle 14)
        push8(10);
        drive_start(0);
        repeat (13) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_run",
              {fsm8, bus8.bf_valid, busy_set8, busy_clr8, done8, 3'(bus8.stage), 3'(bus8.addr_a),
               3'(bus8.addr_b), 2'(bus8.tw_idx)}, 0);
        check("reset_flushed", 32'(exp8_q.size()), 32'd0);
        repeat (3) tick();
        push8(12);
        exp_done_q.push_back(17);
        drive_start(0);
        wait_done(40);
        repeat (3) tick();

        // N=16, no stage gap
        push16();
        exp_done_q.push_back(33);
        drive_start(1);
        wait_done(60);
        repeat (3) tick();

        check("queues_drained",
              32'(exp8_q.size() + exp16_q.size() + exp_done_q.size() + exp_bs_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
